// File: rtl/mp_adder.sv
// mp_adder: 515-bit add/subtract over NCHUNK slice cycles of CHUNK_W bits each.
// Define MP_ADDER_FAST_EN to do the whole operation in a single cycle.
module mp_adder #(
   parameter int CHUNK_W = 128
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic         subtract,
   input  logic [513:0] A,
   input  logic [513:0] B,
   output logic [514:0] C,
   output logic         done
);
   localparam int NCHUNK = (515 + CHUNK_W - 1) / CHUNK_W;
`ifdef MP_ADDER_FAST_EN
   localparam int SW = 515;
   localparam int NS = 1;
`else
   localparam int SW = CHUNK_W;
   localparam int NS = NCHUNK;
`endif
   localparam int PW = SW * NS;
   localparam int CNTW = (NS > 1) ? $clog2(NS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            carry_q, carry_d, done_q, done_d;
   logic [SW:0]     sum;

   // Operands shift down one slice per cycle; results shift in from the top so
   // the final slice lands the full result in place without any index muxing.
   always_comb begin
      sum = {1'b0, a_q[SW-1:0]} + {1'b0, b_q[SW-1:0]} + (SW+1)'(carry_q);
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      cnt_d = cnt_q;
      carry_d = carry_q;
      done_d = done_q;
      if (start && state_q != BUSY) begin
         a_d = PW'({1'b0, A});
         b_d = PW'(subtract ? ~{1'b0, B} : {1'b0, B});
         carry_d = subtract;
         cnt_d = '0;
         done_d = 1'b0;
         state_d = BUSY;
      end else if (state_q == BUSY) begin
         a_d = a_q >> SW;
         b_d = b_q >> SW;
         c_d = (c_q >> SW) | (PW'(sum[SW-1:0]) << (PW - SW));
         carry_d = sum[SW];
         cnt_d = cnt_q + 1'b1;
         done_d = cnt_q == CNTW'(NS - 1);
         state_d = (cnt_q == CNTW'(NS - 1)) ? DONE : BUSY;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         cnt_q <= '0;
         carry_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
         cnt_q <= cnt_d;
         carry_q <= carry_d;
         done_q <= done_d;
      end
   end

   assign C = c_q[514:0];
   assign done = done_q;
endmodule

// File: tb/tb_mp_adder.sv
// tb_mp_adder: directed self-checking bench for mp_adder in either build.
module tb_mp_adder;
`ifdef MP_ADDER_FAST_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 5;
`endif
   localparam int MAXW = 40;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         start = 1'b0;
   logic         subtract = 1'b0;
   logic [513:0] A = '0;
   logic [513:0] B = '0;
   logic [514:0] C;
   logic         done;
   int total = 0;
   int bad = 0;

   mp_adder dut (.clk(clk), .rstn(rstn), .start(start), .subtract(subtract),
                 .A(A), .B(B), .C(C), .done(done));

   always #5 clk = ~clk;

   // Issues one operation, scrambles the inputs after acceptance, waits for done.
   task automatic run_op(input logic [513:0] a, input logic [513:0] b, input logic s,
                         output int lat, output logic d0, output logic [514:0] c);
      @(negedge clk);
      A = a; B = b; subtract = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; A = ~a; B = ~b; subtract = ~s;
      d0 = done;
      lat = 0;
      while (!done && lat < MAXW) begin
         @(posedge clk); #1;
         lat++;
      end
      c = C;
   endtask

   task automatic test_reset;
      #2;
      total++;
      if (C !== 515'd0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset: C=%h done=%b required C=0 done=0", C, done);
      end
      @(negedge clk); rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL idle_done: done=%b required 0", done);
      end
   endtask

   task automatic test_add;
      int lat; logic d0; logic [514:0] c;
      run_op(514'd1, 514'd1, 1'b0, lat, d0, c);
      total++;
      if (d0 !== 1'b0) begin
         bad++;
         $display("FAIL add_done_early: done=%b required 0", d0);
      end
      total++;
      if (lat !== LAT) begin
         bad++;
         $display("FAIL add_latency: got %0d required %0d", lat, LAT);
      end
      total++;
      if (c !== 515'd2) begin
         bad++;
         $display("FAIL add_1_1: C=%h required 2", c);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (done !== 1'b1 || C !== 515'd2) begin
         bad++;
         $display("FAIL done_hold: done=%b C=%h required done=1 C=2", done, C);
      end
   endtask

   task automatic test_subtract;
      int lat; logic d0; logic [514:0] c;
      run_op(514'd1, 514'd1, 1'b1, lat, d0, c);
      total++;
      if (c !== 515'd0 || lat !== LAT) begin
         bad++;
         $display("FAIL sub_1_1: C=%h lat=%0d required C=0 lat=%0d", c, lat, LAT);
      end
      run_op(514'd0, 514'd1, 1'b1, lat, d0, c);
      total++;
      if (c !== {515{1'b1}}) begin
         bad++;
         $display("FAIL sub_0_1: C=%h required all ones", c);
      end
      run_op(514'd7, 514'd5, 1'b1, lat, d0, c);
      total++;
      if (c !== 515'd2) begin
         bad++;
         $display("FAIL sub_7_5: C=%h required 2", c);
      end
      run_op({514{1'b1}}, 514'd1, 1'b1, lat, d0, c);
      total++;
      if (c !== {1'b0, {512{1'b1}}, 2'b10}) begin
         bad++;
         $display("FAIL sub_max_1: C=%h required 2^514-2", c);
      end
   endtask

   task automatic test_carry;
      int lat; logic d0; logic [514:0] c;
      logic [514:0] exp128;
      exp128 = 515'd1 << 128;
      run_op({386'd0, {128{1'b1}}}, 514'd1, 1'b0, lat, d0, c);
      total++;
      if (c !== exp128) begin
         bad++;
         $display("FAIL carry_128: C=%h required %h", c, exp128);
      end
      run_op({514{1'b1}}, {514{1'b1}}, 1'b0, lat, d0, c);
      total++;
      if (c !== {{514{1'b1}}, 1'b0}) begin
         bad++;
         $display("FAIL add_max_max: C=%h required 2^515-2", c);
      end
      run_op({1'b1, 513'd0}, {1'b1, 513'd0}, 1'b0, lat, d0, c);
      total++;
      if (c !== {1'b1, 514'd0}) begin
         bad++;
         $display("FAIL carry_top: C=%h required 2^514", c);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      // done is high from the previous operation here
      @(negedge clk);
      A = 514'd3; B = 514'd4; subtract = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL b2b_done_drop: done=%b required 0", done);
      end
      @(negedge clk);
      A = 514'd100; B = 514'd100; subtract = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < MAXW) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat !== LAT || C !== 515'd7) begin
         bad++;
         $display("FAIL b2b_result: C=%h lat=%0d required C=7 lat=%0d", C, lat, LAT);
      end
      repeat (LAT + 2) @(posedge clk);
      #1;
      total++;
      if (done !== 1'b1 || C !== 515'd7) begin
         bad++;
         $display("FAIL busy_start_ignored: done=%b C=%h required done=1 C=7", done, C);
      end
   endtask

   task automatic test_reset_mid;
      int lat; logic d0; logic [514:0] c;
      @(negedge clk);
      A = {514{1'b1}}; B = 514'd9; subtract = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      #2 rstn = 1'b0;
      #1;
      total++;
      if (C !== 515'd0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: C=%h done=%b required C=0 done=0", C, done);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rstn = 1'b1;
      repeat (LAT + 2) @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL aborted_no_done: done=%b required 0", done);
      end
      run_op(514'd1, 514'd1, 1'b0, lat, d0, c);
      total++;
      if (c !== 515'd2 || lat !== LAT) begin
         bad++;
         $display("FAIL post_reset_add: C=%h lat=%0d required C=2 lat=%0d", c, lat, LAT);
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_subtract;
      test_carry;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
